// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory, with locked bursts.
// Latency: grant is combinational in the request cycle; read data returns registered one cycle later.
// Backpressure: a requester without gnt must hold req/addr/wea/din; gnt0 low stalls the CPU.
module dm_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [3:0]    wea0,
    input  logic [3:0]    wea1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wea,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic       prio;
    owner_t     owner;
    logic [3:0] burst_cnt;

    logic burst_full;
    logic cont0;
    logic cont1;
    logic cont;
    logic rd0;
    logic rd1;

    // A locked owner may only exceed the burst limit while the other side is idle.
    always_comb begin
        burst_full = (burst_cnt >= MAX_B);
        cont0      = (owner == OWN0) && req0 && (!burst_full || !req1);
        cont1      = (owner == OWN1) && req1 && (!burst_full || !req0);
        cont       = cont0 || cont1;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (cont0) begin
            gnt0 = 1'b1;
        end else if (cont1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = !prio;
            gnt1 = prio;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_wea  = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_addr = addr0;
            mem_wea  = wea0;
            mem_din  = din0;
        end else if (gnt1) begin
            mem_addr = addr1;
            mem_wea  = wea1;
            mem_din  = din1;
        end
    end

    assign rd0 = gnt0 && (wea0 == 4'b0000);
    assign rd1 = gnt1 && (wea1 == 4'b0000);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio      <= 1'b0;
            owner     <= OWN_NONE;
            burst_cnt <= 4'd0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                // Priority passes to whichever side did not win this cycle.
                prio <= gnt0;
                if (cont) begin
                    burst_cnt <= burst_full ? MAX_B : burst_cnt + 4'd1;
                end else begin
                    burst_cnt <= 4'd1;
                end
                if (gnt0) begin
                    owner <= lock0 ? OWN0 : OWN_NONE;
                end else begin
                    owner <= lock1 ? OWN1 : OWN_NONE;
                end
            end else begin
                owner     <= OWN_NONE;
                burst_cnt <= 4'd0;
            end
            rvalid0 <= rd0;
            rvalid1 <= rd1;
            if (rd0) begin
                rdata0 <= mem_dout;
            end
            if (rd1) begin
                rdata1 <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus constrained-random traffic against a behavioural model.
module tb_dm_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk;
    logic          rstn;
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [3:0]    wea  [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wea;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] mem     [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    // Reference state: who holds a locked run, its length, and whose turn it is on contention.
    int            m_turn;
    int            m_holder;
    int            m_run;
    logic          m_rv [2];
    logic [DW-1:0] m_rd [2];
    int            last_win;

    int checks;
    int errors;

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req0     (req[0]),
        .req1     (req[1]),
        .lock0    (lock[0]),
        .lock1    (lock[1]),
        .wea0     (wea[0]),
        .wea1     (wea[1]),
        .addr0    (addr[0]),
        .addr1    (addr[1]),
        .din0     (din[0]),
        .din1     (din[1]),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_wea  (mem_wea),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    assign mem_dout = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_turn   = 0;
        m_holder = -1;
        m_run    = 0;
        m_rv[0]  = 1'b0;
        m_rv[1]  = 1'b0;
        m_rd[0]  = '0;
        m_rd[1]  = '0;
    endtask

    task automatic idle_inputs();
        req  = 2'b00;
        lock = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wea[i]  = 4'b0000;
            addr[i] = '0;
            din[i]  = '0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // One clock cycle: predict and check at the falling edge, then advance memory and model at the rising edge.
    task automatic step();
        int            w;
        bit            cont;
        logic [AW-1:0] ea;
        logic [3:0]    ew;
        logic [DW-1:0] ed;
        logic [AW-1:0] sa;
        logic [3:0]    sw;
        logic [DW-1:0] sd;
        w    = -1;
        cont = 1'b0;
        @(negedge clk);
        if (m_holder >= 0 && req[m_holder] && (m_run < MAXB || !req[1 - m_holder])) begin
            w    = m_holder;
            cont = 1'b1;
        end else if (req[0] && req[1]) begin
            w = m_turn;
        end else if (req[0]) begin
            w = 0;
        end else if (req[1]) begin
            w = 1;
        end
        ea = (w >= 0) ? addr[w] : '0;
        ew = (w >= 0) ? wea[w]  : 4'b0000;
        ed = (w >= 0) ? din[w]  : '0;
        chk("gnt0", 64'(gnt0), 64'(w == 0));
        chk("gnt1", 64'(gnt1), 64'(w == 1));
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        chk("mem_wea", 64'(mem_wea), 64'(ew));
        chk("mem_din", 64'(mem_din), 64'(ed));
        chk("rvalid0", 64'(rvalid0), 64'(m_rv[0]));
        chk("rvalid1", 64'(rvalid1), 64'(m_rv[1]));
        chk("rdata0", 64'(rdata0), 64'(m_rd[0]));
        chk("rdata1", 64'(rdata1), 64'(m_rd[1]));
        sa = mem_addr;
        sw = mem_wea;
        sd = mem_din;
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            if (sw[b]) mem[sa][8*b +: 8] = sd[8*b +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = (w == i) && (wea[i] == 4'b0000);
            if (m_rv[i]) m_rd[i] = ref_mem[addr[i]];
        end
        if (w >= 0) begin
            for (int b = 0; b < 4; b++) begin
                if (wea[w][b]) ref_mem[addr[w]][8*b +: 8] = din[w][8*b +: 8];
            end
            m_turn   = 1 - w;
            m_run    = cont ? ((m_run + 1 > MAXB) ? MAXB : m_run + 1) : 1;
            m_holder = lock[w] ? w : -1;
        end else begin
            m_holder = -1;
            m_run    = 0;
        end
        last_win = w;
        #1;
    endtask

    initial begin
        int wins[$];
        int exp2[6];
        int exp3[5];
        checks   = 0;
        errors   = 0;
        last_win = -1;
        exp2     = '{0, 1, 0, 1, 0, 1};
        exp3     = '{1, 1, 1, 1, 0};
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'h1000_0000 + DW'(i * 7);
            ref_mem[i] = mem[i];
        end
        mem[4]      = 32'hDEADBEEF;
        ref_mem[4]  = 32'hDEADBEEF;
        mem[16]     = 32'hAAAAAAAA;
        ref_mem[16] = 32'hAAAAAAAA;
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        #12;
        chk("reset_gnt", 64'({gnt1, gnt0}), 64'd0);
        chk("reset_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
        chk("reset_rdata0", 64'(rdata0), 64'd0);
        chk("reset_rdata1", 64'(rdata1), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single read by requester 0.
        req[0]  = 1'b1;
        addr[0] = 10'h004;
        step();
        chk("t1_win", 64'(last_win), 64'd0);
        chk("t1_rdata0", 64'(rdata0), 64'hDEADBEEF);
        req[0] = 1'b0;
        step();

        // Contention without lock alternates, starting with requester 0.
        do_reset();
        req     = 2'b11;
        addr[0] = 10'h004;
        addr[1] = 10'h010;
        wins.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            wins.push_back(last_win);
        end
        for (int i = 0; i < 6; i++) chk("t2_order", 64'(wins[i]), 64'(exp2[i]));
        idle_inputs();
        step();

        // Locked burst by requester 1 capped at MAX_BURST.
        do_reset();
        req[1]  = 1'b1;
        lock[1] = 1'b1;
        addr[1] = 10'h020;
        wins.delete();
        step();
        wins.push_back(last_win);
        req[0]  = 1'b1;
        addr[0] = 10'h030;
        for (int i = 0; i < 4; i++) begin
            step();
            wins.push_back(last_win);
        end
        for (int i = 0; i < 5; i++) chk("t3_order", 64'(wins[i]), 64'(exp3[i]));
        idle_inputs();
        step();

        // Uncontended locked run saturates the burst count; a late request still wins at once.
        do_reset();
        req[0]  = 1'b1;
        lock[0] = 1'b1;
        addr[0] = 10'h040;
        for (int i = 0; i < 10; i++) step();
        chk("t4_burst_sat", 64'(dut.burst_cnt), 64'd4);
        req[1]  = 1'b1;
        addr[1] = 10'h050;
        step();
        chk("t4_late_win", 64'(last_win), 64'd1);
        idle_inputs();
        step();

        // Partial-byte write then read back.
        req[0]  = 1'b1;
        addr[0] = 10'h010;
        wea[0]  = 4'b0011;
        din[0]  = 32'h12345678;
        step();
        chk("t5_write_win", 64'(last_win), 64'd0);
        chk("t5_no_rvalid", 64'(rvalid0), 64'd0);
        wea[0] = 4'b0000;
        din[0] = '0;
        step();
        chk("t5_readback", 64'(rdata0), 64'hAAAA5678);
        idle_inputs();
        step();

        // Constrained-random traffic honouring the hold-until-granted rule.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || last_win == i) begin
                    req[i]  = ($urandom_range(0, 3) != 0);
                    lock[i] = ($urandom_range(0, 2) == 0);
                    wea[i]  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
                    addr[i] = AW'($urandom_range(0, 31));
                    din[i]  = $urandom;
                end
            end
            step();
        end
        idle_inputs();
        step();

        // Reset in the middle of a locked burst with a read outstanding.
        req[1]  = 1'b1;
        lock[1] = 1'b1;
        addr[1] = 10'h004;
        step();
        req[0]  = 1'b1;
        addr[0] = 10'h010;
        step();
        chk("t6_pending", 64'(rvalid1), 64'd1);
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_rvalid1", 64'(rvalid1), 64'd0);
        chk("t6_rdata1", 64'(rdata1), 64'd0);
        chk("t6_gnt1", 64'(gnt1), 64'd0);
        chk("t6_gnt0", 64'(gnt0), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        chk("t6_first_win", 64'(last_win), 64'd0);
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU and a second master, such as a debug or loader port. It issues at most one grant per cycle under round-robin priority, with optional locked bursts bounded by `MAX_BURST`. It steers address, byte enables and write data to memory, and returns registered read data to the winner one cycle later. Any requester not granted must hold its request; the CPU treats `gnt0` low as a stall/clock-enable.

## Interface
- `AW`, 10: word-in-byte address width presented to memory.
- `DW`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive locked grants while the other requester waits; legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `req0` / `req1`  in  1  access request from requester 0 (CPU) / requester 1.
- `lock0` / `lock1`  in  1  requests grant continuation on the next cycle.
- `wea0` / `wea1`  in  4  byte write enables; 0000 means read.
- `addr0` / `addr1`  in  AW  address.
- `din0` / `din1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  grant, combinational in the request cycle.
- `rvalid0` / `rvalid1`  out  1  read data valid, registered.
- `rdata0` / `rdata1`  out  DW  read data, registered.
- `mem_addr`  out  AW  memory address.
- `mem_wea`  out  4  memory byte enables.
- `mem_din`  out  DW  memory write data.
- `mem_dout`  in  DW  memory read data; combinational from `mem_addr`.

## Operation
**State registers**
- `prio`: 1 bit, reset 0.
- `owner`: NONE/OWN0/OWN1, reset NONE.
- `burst_cnt`: 4 bits, reset 0.
- `rvalid0`, `rvalid1`: reset 0.
- `rdata0`, `rdata1`: reset 0.

**Grant decision (combinational, each cycle)**
1. Continuation: if `owner`=X, `reqX`=1, and (`burst_cnt`<`MAX_BURST` or the other requester's `req`=0), grant X.
2. Otherwise, if both requests are high, grant the requester selected by `prio`.
3. Otherwise, grant the only requester with `req` high.
4. Otherwise, no grant.
- `gnt0` and `gnt1` are never high together. A grant is never issued without its `req`.

**Memory steering**
- Granted requester's `addr`, `wea` and `din` drive `mem_*` unmodified.
- With no grant: `mem_wea`=0, `mem_addr`=0, `mem_din`=0.

**Edge update when X is granted**
- `prio` <= other requester.
- `burst_cnt` <= min(`burst_cnt`+1, `MAX_BURST`) if the grant came from rule 1; otherwise 1.
- `owner` <= X if `lockX`=1, else NONE.

**Edge update with no grant**
- `owner` <= NONE, `burst_cnt` <= 0.

**Read return**
- `rvalidX` <= `gntX` & (`weaX`==0).
- When that term is 1, `rdataX` <= `mem_dout`; otherwise `rdataX` holds its previous value.
- A write (any `wea` bit set) never produces `rvalid`.

**Lock and reset behaviour**
- Lock without a following request: if `reqX` drops while `owner`=X, normal arbitration applies that cycle.
- Reset mid-operation: all registers clear immediately. The grant logic sees `owner`=NONE; a pending `rvalid` is dropped and not replayed.

## Timing
- Grant latency: 0 cycles (same cycle as `req`).
- Read data latency: 1 cycle after the grant cycle.
- Write commits at the edge ending the grant cycle.
- Throughput: one access per cycle in aggregate.
- Under contention without lock, grants alternate every cycle.
- Worst-case wait for a requester whose `req` is held high: `MAX_BURST` cycles.
- First grant after reset release under contention goes to requester 0.
- Requester obligations: hold `req`/`addr`/`wea`/`din` stable until it sees `gnt` high at a clock edge; may change them in the cycle after the grant.

## Test plan
1. Memory word 0x004 = 0xDEADBEEF; only `req0`, read `addr0`=0x004 → `gnt0`=1 in the same cycle, `mem_addr`=0x004; next cycle `rvalid0`=1, `rdata0`=0xDEADBEEF; `gnt1` and `rvalid1` stay 0.
2. After reset, `req0`=`req1`=1 held for 6 cycles, no lock → grants 0,1,0,1,0,1; each read returns on the matching `rvalid` one cycle later.
3. `MAX_BURST`=4; `req1`=`lock1`=1 granted first, then `req0` rises → `gnt1` for 4 consecutive cycles, then `gnt0` on cycle 5.
4. `req0`=`lock0`=1 with `req1`=0 for 10 cycles → `gnt0` every cycle; `burst_cnt` saturates at 4; `req1` rising in cycle 11 is granted in cycle 11.
5. `req0` write, `addr0`=0x010, `wea0`=0011, `din0`=0x12345678 over prior 0xAAAAAAAA → `mem_wea`=0011, `rvalid0` stays 0; a following read of 0x010 returns 0xAAAA5678.
6. Drop `rstn` during a locked burst by requester 1 with a read pending → `gnt1`, `rvalid1` and `rdata1` go to 0 immediately; after `rstn` rises with both requesting, `gnt0` is granted first.
